// File: rtl/bc_msg_arb.sv
// Round-robin arbiter that funnels per-core broadcast messages into one registered output slot.
// Masked (in-reset) cores are drained and counted as drops, so they are never granted.
module bc_msg_arb #(
  parameter int CORE_COUNT    = 16,
  parameter int MSG_WIDTH     = 47,
  parameter int CORE_ID_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg,
  input  logic [CORE_COUNT-1:0]           s_valid,
  output logic [CORE_COUNT-1:0]           s_ready,
  input  logic [CORE_COUNT-1:0]           core_mask,
  output logic [MSG_WIDTH-1:0]            m_msg,
  output logic [CORE_ID_WIDTH-1:0]        m_src,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [15:0]                     drop_count,
  output logic [31:0]                     msg_count
);

  localparam logic [CORE_ID_WIDTH:0]   LP_COUNT = (CORE_ID_WIDTH+1)'(CORE_COUNT);
  localparam logic [CORE_ID_WIDTH-1:0] LP_LAST  = CORE_ID_WIDTH'(CORE_COUNT - 1);

  logic [MSG_WIDTH-1:0]     r_m_msg;
  logic [CORE_ID_WIDTH-1:0] r_m_src;
  logic                     r_m_valid;
  logic [CORE_ID_WIDTH-1:0] r_ptr;
  logic [15:0]              r_drop_count;
  logic [31:0]              r_msg_count;

  logic [CORE_COUNT-1:0]    w_cand;
  logic [CORE_COUNT-1:0]    w_drop;
  logic                     w_load;
  logic                     w_found;
  logic                     w_take;
  logic [CORE_ID_WIDTH-1:0] w_gnt_idx;
  logic [CORE_ID_WIDTH:0]   w_sum;
  logic [CORE_ID_WIDTH-1:0] w_next_ptr;
  logic [MSG_WIDTH-1:0]     w_gnt_msg;
  logic [CORE_ID_WIDTH:0]   w_drop_num;
  logic [16:0]              w_drop_sum;

  assign w_cand = s_valid & ~core_mask;
  assign w_drop = s_valid & core_mask;
  assign w_load = !r_m_valid || m_ready;

  // Scan from the farthest slot back toward ptr so the nearest candidate wins last.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    for (int k = CORE_COUNT - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (CORE_ID_WIDTH+1)'(k);
      if (w_sum >= LP_COUNT) w_sum = w_sum - LP_COUNT;
      if (w_cand[w_sum[CORE_ID_WIDTH-1:0]]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_sum[CORE_ID_WIDTH-1:0];
      end
    end
  end

  // Gating with rst_n keeps unmasked readies low while reset is held.
  assign w_take     = w_load && w_found && rst_n;
  assign w_next_ptr = (w_gnt_idx == LP_LAST) ? '0 : w_gnt_idx + 1'b1;
  assign w_gnt_msg  = s_msg[w_gnt_idx*MSG_WIDTH +: MSG_WIDTH];

  generate
    for (genvar gi = 0; gi < CORE_COUNT; gi++) begin : g_ready
      assign s_ready[gi] = core_mask[gi] ? s_valid[gi]
                                         : (w_take && (w_gnt_idx == CORE_ID_WIDTH'(gi)));
    end
  endgenerate

  always_comb begin
    w_drop_num = '0;
    for (int k = 0; k < CORE_COUNT; k++) begin
      w_drop_num = w_drop_num + (CORE_ID_WIDTH+1)'(w_drop[k]);
    end
    w_drop_sum = {1'b0, r_drop_count} + 17'(w_drop_num);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_msg      <= '0;
      r_m_src      <= '0;
      r_m_valid    <= 1'b0;
      r_ptr        <= '0;
      r_drop_count <= '0;
      r_msg_count  <= '0;
    end else begin
      if (w_take) begin
        r_m_msg   <= w_gnt_msg;
        r_m_src   <= w_gnt_idx;
        r_m_valid <= 1'b1;
        r_ptr     <= w_next_ptr;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (r_m_valid && m_ready) r_msg_count <= r_msg_count + 32'd1;
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign m_msg      = r_m_msg;
  assign m_src      = r_m_src;
  assign m_valid    = r_m_valid;
  assign drop_count = r_drop_count;
  assign msg_count  = r_msg_count;

endmodule

// File: tb/tb_bc_msg_arb.sv
// Directed testbench for bc_msg_arb: reset, single grant, fairness, backpressure,
// masking with drop saturation, mid-operation reset and delivery-counter wrap.
module tb_bc_msg_arb;

  localparam int CC = 16;
  localparam int MW = 47;
  localparam int IW = 4;

  logic             clk;
  logic             rst_n;
  logic [CC*MW-1:0] s_msg;
  logic [CC-1:0]    s_valid;
  logic [CC-1:0]    s_ready;
  logic [CC-1:0]    core_mask;
  logic [MW-1:0]    m_msg;
  logic [IW-1:0]    m_src;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      drop_count;
  logic [31:0]      msg_count;

  int vectors;
  int miscompares;

  bc_msg_arb #(.CORE_COUNT(CC), .MSG_WIDTH(MW), .CORE_ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .s_msg(s_msg), .s_valid(s_valid), .s_ready(s_ready),
    .core_mask(core_mask), .m_msg(m_msg), .m_src(m_src), .m_valid(m_valid),
    .m_ready(m_ready), .drop_count(drop_count), .msg_count(msg_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

  function automatic logic [MW-1:0] pat(input int i);
    return {15'h1A5A ^ 15'(i), 32'hC0DE_0000 + 32'(i)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; s_valid = '0; core_mask = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 16'hFFFF; core_mask = '0; m_ready = 1'b1;
    #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_m_valid got %0b want 0", m_valid); end
    vectors++; if (m_msg !== '0) begin miscompares++; $display("FAIL rst_m_msg got %h want 0", m_msg); end
    vectors++; if (m_src !== 4'd0) begin miscompares++; $display("FAIL rst_m_src got %0d want 0", m_src); end
    vectors++; if (s_ready !== 16'h0000) begin miscompares++; $display("FAIL rst_s_ready got %h want 0000", s_ready); end
    vectors++; if (drop_count !== 16'd0 || msg_count !== 32'd0) begin miscompares++; $display("FAIL rst_counts got %0d/%0d want 0/0", drop_count, msg_count); end
    @(posedge clk); #1;
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid got %0b want 0", m_valid); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    m_ready = 1'b1; s_valid = 16'h0004;
    #1;
    vectors++; if (s_ready !== 16'h0004) begin miscompares++; $display("FAIL single_ready got %h want 0004", s_ready); end
    @(posedge clk); #1;
    vectors++; if (m_valid !== 1'b1 || m_src !== 4'd2) begin miscompares++; $display("FAIL single_out got v=%0b src=%0d want v=1 src=2", m_valid, m_src); end
    vectors++; if (m_msg !== pat(2)) begin miscompares++; $display("FAIL single_msg got %h want %h", m_msg, pat(2)); end
    s_valid = '0;
    @(posedge clk); #1;
    vectors++; if (msg_count !== 32'd1 || m_valid !== 1'b0) begin miscompares++; $display("FAIL single_count got cnt=%0d v=%0b want 1/0", msg_count, m_valid); end
    repeat (2) @(posedge clk);
    #1; s_valid = 16'h0009;
    #1;
    vectors++; if (s_ready !== 16'h0008) begin miscompares++; $display("FAIL single_ptr got %h want 0008", s_ready); end
    s_valid = '0;
    $display("test_single done");
  endtask

  task automatic test_fairness();
    int errs;
    do_reset();
    errs = 0;
    m_ready = 1'b1; s_valid = 16'hFFFF;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (m_valid !== 1'b1 || m_src !== 4'(c % 16) || m_msg !== pat(c % 16)) begin
        miscompares++;
        $display("FAIL fair_seq cycle %0d got v=%0b src=%0d want v=1 src=%0d", c, m_valid, m_src, c % 16);
      end
    end
    s_valid = '0;
    @(posedge clk); #1;
    vectors++; if (msg_count !== 32'd32 || m_valid !== 1'b0) begin miscompares++; $display("FAIL fair_count got cnt=%0d v=%0b want 32/0", msg_count, m_valid); end
    $display("test_fairness done");
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0; s_valid = 16'h0020;
    @(posedge clk); #1;
    s_valid = 16'h0040;
    for (int c = 0; c < 4; c++) begin
      #1;
      vectors++;
      if (s_ready !== 16'h0000 || m_valid !== 1'b1 || m_src !== 4'd5 || m_msg !== pat(5)) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d got rdy=%h v=%0b src=%0d want 0000/1/5", c, s_ready, m_valid, m_src);
      end
      @(posedge clk);
    end
    #1; m_ready = 1'b1;
    #1;
    vectors++; if (s_ready !== 16'h0040) begin miscompares++; $display("FAIL bp_release_ready got %h want 0040", s_ready); end
    @(posedge clk); #1;
    vectors++; if (m_src !== 4'd6 || m_msg !== pat(6) || msg_count !== 32'd1) begin miscompares++; $display("FAIL bp_next got src=%0d cnt=%0d want 6/1", m_src, msg_count); end
    s_valid = '0;
    $display("test_backpressure done");
  endtask

  task automatic test_mask();
    do_reset();
    m_ready = 1'b1; core_mask = 16'h0001; s_valid = 16'h0003;
    #1;
    vectors++; if (s_ready !== 16'h0003) begin miscompares++; $display("FAIL mask_ready got %h want 0003", s_ready); end
    @(posedge clk); #1;
    vectors++; if (drop_count !== 16'd1 || m_src !== 4'd1 || m_valid !== 1'b1) begin miscompares++; $display("FAIL mask_drop got drop=%0d src=%0d want 1/1", drop_count, m_src); end
    core_mask = 16'hFFFF; s_valid = 16'hFFFF;
    #1;
    vectors++; if (s_ready !== 16'hFFFF) begin miscompares++; $display("FAIL mask_all_ready got %h want ffff", s_ready); end
    repeat (4095) @(posedge clk);
    #1;
    vectors++; if (drop_count !== 16'hFFF1) begin miscompares++; $display("FAIL mask_accum got %h want fff1", drop_count); end
    repeat (280) @(posedge clk);
    #1;
    vectors++; if (drop_count !== 16'hFFFF) begin miscompares++; $display("FAIL mask_sat got %h want ffff", drop_count); end
    vectors++; if (m_valid !== 1'b0 || msg_count !== 32'd1) begin miscompares++; $display("FAIL mask_nogrant got v=%0b cnt=%0d want 0/1", m_valid, msg_count); end
    s_valid = '0; core_mask = '0;
    $display("test_mask done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_ready = 1'b0; s_valid = 16'h0020;
    @(posedge clk); #3;
    rst_n = 1'b0; s_valid = 16'h8001;
    #1;
    vectors++; if (m_valid !== 1'b0 || m_src !== 4'd0 || m_msg !== '0) begin miscompares++; $display("FAIL midrst_async got v=%0b src=%0d want 0/0", m_valid, m_src); end
    vectors++; if (s_ready !== 16'h0000) begin miscompares++; $display("FAIL midrst_ready got %h want 0000", s_ready); end
    @(negedge clk);
    rst_n = 1'b1; m_ready = 1'b1;
    #1;
    vectors++; if (s_ready !== 16'h0001) begin miscompares++; $display("FAIL midrst_first_ready got %h want 0001", s_ready); end
    @(posedge clk); #1;
    vectors++; if (m_valid !== 1'b1 || m_src !== 4'd0 || m_msg !== pat(0)) begin miscompares++; $display("FAIL midrst_first got v=%0b src=%0d want 1/0", m_valid, m_src); end
    @(posedge clk); #1;
    vectors++; if (m_src !== 4'd15 || m_msg !== pat(15)) begin miscompares++; $display("FAIL midrst_second got src=%0d want 15", m_src); end
    s_valid = '0;
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap();
    do_reset();
    m_ready = 1'b0; s_valid = '0;
    force dut.r_msg_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_msg_count;
    #1;
    vectors++; if (msg_count !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_preset got %h want ffffffff", msg_count); end
    m_ready = 1'b1; s_valid = 16'h0001;
    @(posedge clk); #1;
    s_valid = '0;
    @(posedge clk); #1;
    vectors++; if (msg_count !== 32'd0 || m_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_zero got cnt=%h v=%0b want 0/0", msg_count, m_valid); end
    $display("test_wrap done");
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; s_valid = '0; core_mask = '0; m_ready = 1'b0;
    for (int i = 0; i < CC; i++) s_msg[i*MW +: MW] = pat(i);
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_mask();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
